// File: rtl/ram_arb_pkg.sv
// Shared types and the round-robin helper for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int ReqIdBits = 1;

  typedef logic [ReqIdBits-1:0] req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // A lone valid requester wins; on a tie the one not served last wins.
  function automatic req_id_t rr_next_grant(input logic v0, input logic v1,
                                            input req_id_t last_grant);
    req_id_t g;
    if (v0 && !v1) begin
      g = REQ0;
    end else if (v1 && !v0) begin
      g = REQ1;
    end else begin
      g = (last_grant == REQ0) ? REQ1 : REQ0;
    end
    return g;
  endfunction

endpackage

// File: rtl/ram_arb_tagq.sv
// In-order queue of requester ids, one entry per outstanding read.
module ram_arb_tagq
  import ram_arb_pkg::*;
#(
  parameter int TagDepth = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output req_id_t head,
  output logic    empty,
  output logic    full
);

  localparam int PtrBits = $clog2(TagDepth);

  req_id_t              slots [TagDepth];
  logic [PtrBits-1:0]   wr_ptr;
  logic [PtrBits-1:0]   rd_ptr;
  logic [PtrBits:0]     count;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PtrBits+1)'(TagDepth));
  assign head    = slots[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers are PtrBits wide, so they wrap modulo TagDepth on their own.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_id;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_1port_arb2.sv
// Round-robin sharing of one single-port RAM between two requesters,
// with acks routed back to the requester that issued each read.
module ram_1port_arb2
  import ram_arb_pkg::*;
#(
  parameter int Width    = 16,
  parameter int AddrBits = 8,
  parameter int TagDepth = 4
) (
  input  logic                clk,
  input  logic                reset,
  // Handshake: a transfer happens on a cycle with valid=1 and retry=0;
  // the sender holds valid and payload stable until that cycle.
  input  logic                r0_req_valid,
  output logic                r0_req_retry,
  input  logic                r0_req_we,
  input  logic [AddrBits-1:0] r0_req_addr,
  input  logic [Width-1:0]    r0_req_data,
  input  logic                r1_req_valid,
  output logic                r1_req_retry,
  input  logic                r1_req_we,
  input  logic [AddrBits-1:0] r1_req_addr,
  input  logic [Width-1:0]    r1_req_data,
  output logic                r0_ack_valid,
  input  logic                r0_ack_retry,
  output logic [Width-1:0]    r0_ack_data,
  output logic                r1_ack_valid,
  input  logic                r1_ack_retry,
  output logic [Width-1:0]    r1_ack_data,
  output logic                mem_req_valid,
  input  logic                mem_req_retry,
  output logic                mem_req_we,
  output logic [AddrBits-1:0] mem_req_addr,
  output logic [Width-1:0]    mem_req_data,
  input  logic                mem_ack_valid,
  output logic                mem_ack_retry,
  input  logic [Width-1:0]    mem_ack_data,
  output logic                err_ack,
  output arb_state_t          dbg_state
);

  arb_state_t          state;
  req_id_t             held;
  req_id_t             last_grant;
  req_id_t             grant;
  logic                g_valid;
  logic                g_we;
  logic [AddrBits-1:0] g_addr;
  logic [Width-1:0]    g_data;
  logic                blocked;
  logic                xfer;
  logic                q_push;
  logic                q_pop;
  logic                q_empty;
  logic                q_full;
  req_id_t             q_head;
  logic                head_retry;

  always_comb begin
    grant = (state == ARB_LOCKED) ? held
                                  : rr_next_grant(r0_req_valid, r1_req_valid, last_grant);
    if (grant == REQ1) begin
      g_valid = r1_req_valid;
      g_we    = r1_req_we;
      g_addr  = r1_req_addr;
      g_data  = r1_req_data;
    end else begin
      g_valid = r0_req_valid;
      g_we    = r0_req_we;
      g_addr  = r0_req_addr;
      g_data  = r0_req_data;
    end
  end

  // Occupancy is the registered count, so a same-cycle pop cannot unblock a read.
  assign blocked       = g_valid & ~g_we & q_full;
  assign mem_req_valid = reset & g_valid & ~blocked;
  assign mem_req_we    = g_we;
  assign mem_req_addr  = g_addr;
  assign mem_req_data  = g_data;
  assign xfer          = mem_req_valid & ~mem_req_retry;

  assign r0_req_retry = ~reset | (grant != REQ0) | blocked | mem_req_retry;
  assign r1_req_retry = ~reset | (grant != REQ1) | blocked | mem_req_retry;

  assign q_push     = xfer & ~g_we;
  assign head_retry = (q_head == REQ1) ? r1_ack_retry : r0_ack_retry;
  assign q_pop      = reset & mem_ack_valid & ~q_empty & ~head_retry;

  // With the queue empty an ack has no owner: it is dropped, never stalled.
  assign mem_ack_retry = ~reset | (~q_empty & head_retry);
  assign r0_ack_valid  = reset & mem_ack_valid & ~q_empty & (q_head == REQ0);
  assign r1_ack_valid  = reset & mem_ack_valid & ~q_empty & (q_head == REQ1);
  assign r0_ack_data   = mem_ack_data;
  assign r1_ack_data   = mem_ack_data;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB_FREE;
      held       <= REQ0;
      last_grant <= REQ1;
      err_ack    <= 1'b0;
    end else begin
      case (state)
        ARB_FREE: begin
          if (mem_req_valid && mem_req_retry) begin
            state <= ARB_LOCKED;
            held  <= grant;
          end
        end
        ARB_LOCKED: begin
          if (xfer) begin
            state <= ARB_FREE;
          end
        end
        default: state <= ARB_FREE;
      endcase
      if (xfer) begin
        last_grant <= grant;
      end
      if (mem_ack_valid && q_empty) begin
        err_ack <= 1'b1;
      end
    end
  end

  ram_arb_tagq #(
    .TagDepth(TagDepth)
  ) u_tagq (
    .clk    (clk),
    .reset  (reset),
    .push   (q_push),
    .push_id(grant),
    .pop    (q_pop),
    .head   (q_head),
    .empty  (q_empty),
    .full   (q_full)
  );

endmodule

// File: tb/tb_ram_1port_arb2.sv
// Directed cycle-by-cycle vectors for the two-requester RAM arbiter, plus a
// hand-written contention sequence.
module tb_ram_1port_arb2;
  import ram_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic        r0_req_valid, r0_req_retry, r0_req_we;
  logic [7:0]  r0_req_addr;
  logic [15:0] r0_req_data;
  logic        r1_req_valid, r1_req_retry, r1_req_we;
  logic [7:0]  r1_req_addr;
  logic [15:0] r1_req_data;
  logic        r0_ack_valid, r0_ack_retry;
  logic [15:0] r0_ack_data;
  logic        r1_ack_valid, r1_ack_retry;
  logic [15:0] r1_ack_data;
  logic        mem_req_valid, mem_req_retry, mem_req_we;
  logic [7:0]  mem_req_addr;
  logic [15:0] mem_req_data;
  logic        mem_ack_valid, mem_ack_retry;
  logic [15:0] mem_ack_data;
  logic        err_ack;
  arb_state_t  dbg_state;

  int total;
  int bad;

  ram_1port_arb2 dut (
    .clk(clk), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_retry(r0_req_retry), .r0_req_we(r0_req_we),
    .r0_req_addr(r0_req_addr), .r0_req_data(r0_req_data),
    .r1_req_valid(r1_req_valid), .r1_req_retry(r1_req_retry), .r1_req_we(r1_req_we),
    .r1_req_addr(r1_req_addr), .r1_req_data(r1_req_data),
    .r0_ack_valid(r0_ack_valid), .r0_ack_retry(r0_ack_retry), .r0_ack_data(r0_ack_data),
    .r1_ack_valid(r1_ack_valid), .r1_ack_retry(r1_ack_retry), .r1_ack_data(r1_ack_data),
    .mem_req_valid(mem_req_valid), .mem_req_retry(mem_req_retry), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_ack_valid(mem_ack_valid), .mem_ack_retry(mem_ack_retry), .mem_ack_data(mem_ack_data),
    .err_ack(err_ack), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0, we0;
    logic [7:0]  a0;
    logic [15:0] d0;
    logic        v1, we1;
    logic [7:0]  a1;
    logic [15:0] d1;
    logic        mrr, mav;
    logic [15:0] mad;
    logic        ar0, ar1;
    logic        e_mrv, e_mwe;
    logic [7:0]  e_addr;
    logic [15:0] e_data;
    logic        e_rr0, e_rr1, e_av0, e_av1, e_mar, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst,
                     input logic v0, input logic we0, input logic [7:0] a0, input logic [15:0] d0,
                     input logic v1, input logic we1, input logic [7:0] a1, input logic [15:0] d1,
                     input logic mrr, input logic mav, input logic [15:0] mad,
                     input logic ar0, input logic ar1,
                     input logic e_mrv, input logic e_mwe, input logic [7:0] e_addr,
                     input logic [15:0] e_data,
                     input logic e_rr0, input logic e_rr1, input logic e_av0, input logic e_av1,
                     input logic e_mar, input logic e_err);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.mrr = mrr; v.mav = mav; v.mad = mad; v.ar0 = ar0; v.ar1 = ar1;
    v.e_mrv = e_mrv; v.e_mwe = e_mwe; v.e_addr = e_addr; v.e_data = e_data;
    v.e_rr0 = e_rr0; v.e_rr1 = e_rr1; v.e_av0 = e_av0; v.e_av1 = e_av1;
    v.e_mar = e_mar; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  // driver tasks
  task automatic drive_vec(input vec_t v);
    reset         = v.rst;
    r0_req_valid  = v.v0;  r0_req_we = v.we0; r0_req_addr = v.a0; r0_req_data = v.d0;
    r1_req_valid  = v.v1;  r1_req_we = v.we1; r1_req_addr = v.a1; r1_req_data = v.d1;
    mem_req_retry = v.mrr;
    mem_ack_valid = v.mav; mem_ack_data = v.mad;
    r0_ack_retry  = v.ar0; r1_ack_retry = v.ar1;
  endtask

  task automatic drive_idle();
    r0_req_valid = 1'b0; r0_req_we = 1'b0; r0_req_addr = '0; r0_req_data = '0;
    r1_req_valid = 1'b0; r1_req_we = 1'b0; r1_req_addr = '0; r1_req_data = '0;
    mem_req_retry = 1'b0; mem_ack_valid = 1'b0; mem_ack_data = '0;
    r0_ack_retry = 1'b0; r1_ack_retry = 1'b0;
  endtask

  // scoreboard: one comparison per vector, idle-requester retries ignored
  task automatic check_vec(input int idx, input vec_t v);
    logic ok;
    ok = 1'b1;
    if (mem_req_valid !== v.e_mrv) ok = 1'b0;
    if (v.e_mrv && (mem_req_we !== v.e_mwe || mem_req_addr !== v.e_addr)) ok = 1'b0;
    if (v.e_mrv && v.e_mwe && mem_req_data !== v.e_data) ok = 1'b0;
    if ((v.v0 || !v.rst) && r0_req_retry !== v.e_rr0) ok = 1'b0;
    if ((v.v1 || !v.rst) && r1_req_retry !== v.e_rr1) ok = 1'b0;
    if (r0_ack_valid !== v.e_av0 || r1_ack_valid !== v.e_av1) ok = 1'b0;
    if (v.e_av0 && r0_ack_data !== v.mad) ok = 1'b0;
    if (v.e_av1 && r1_ack_data !== v.mad) ok = 1'b0;
    if (mem_ack_retry !== v.e_mar || err_ack !== v.e_err) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL vec%0d: got mrv=%b we=%b addr=%h data=%h rr=%b%b av=%b%b ad=%h/%h mar=%b err=%b ; want mrv=%b we=%b addr=%h data=%h rr=%b%b av=%b%b ad=%h mar=%b err=%b",
               idx, mem_req_valid, mem_req_we, mem_req_addr, mem_req_data,
               r0_req_retry, r1_req_retry, r0_ack_valid, r1_ack_valid, r0_ack_data, r1_ack_data,
               mem_ack_retry, err_ack,
               v.e_mrv, v.e_mwe, v.e_addr, v.e_data, v.e_rr0, v.e_rr1, v.e_av0, v.e_av1,
               v.mad, v.e_mar, v.e_err);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);

    //   rst  r0:v we a d             r1:v we a d             mrr mav mad      ar0 ar1  exp: mrv we addr data      rr0 rr1 av0 av1 mar err
    // write then read by r0 (first row still in reset)
    add(0, 1,1,8'h10,16'hBEEF, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 0,0,8'h00,16'h0000, 1,1,0,0,1,0);
    add(1, 1,1,8'h10,16'hBEEF, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 1,1,8'h10,16'hBEEF, 0,0,0,0,0,0);
    add(1, 1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h10,16'h0000, 0,0,0,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'hBEEF,0,0, 0,0,8'h00,16'h0000, 0,0,1,0,0,0);
    // both valid, r1 wins the tie and is held through three retry cycles
    add(1, 1,1,8'h40,16'h1111, 1,1,8'h41,16'h2222, 1, 0,16'h0000,0,0, 1,1,8'h41,16'h2222, 1,1,0,0,0,0);
    add(1, 1,1,8'h40,16'h1111, 1,1,8'h41,16'h2222, 1, 0,16'h0000,0,0, 1,1,8'h41,16'h2222, 1,1,0,0,0,0);
    add(1, 1,1,8'h40,16'h1111, 1,1,8'h41,16'h2222, 1, 0,16'h0000,0,0, 1,1,8'h41,16'h2222, 1,1,0,0,0,0);
    add(1, 1,1,8'h40,16'h1111, 1,1,8'h41,16'h2222, 0, 0,16'h0000,0,0, 1,1,8'h41,16'h2222, 1,0,0,0,0,0);
    add(1, 1,1,8'h40,16'h1111, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 1,1,8'h40,16'h1111, 0,0,0,0,0,0);
    // lock on lone r0 survives r1 arriving with tie priority
    add(1, 1,1,8'h50,16'h3333, 0,0,8'h00,16'h0000, 1, 0,16'h0000,0,0, 1,1,8'h50,16'h3333, 1,0,0,0,0,0);
    add(1, 1,1,8'h50,16'h3333, 1,1,8'h51,16'h4444, 1, 0,16'h0000,0,0, 1,1,8'h50,16'h3333, 1,1,0,0,0,0);
    add(1, 1,1,8'h50,16'h3333, 1,1,8'h51,16'h4444, 0, 0,16'h0000,0,0, 1,1,8'h50,16'h3333, 0,1,0,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 1,1,8'h51,16'h4444, 0, 0,16'h0000,0,0, 1,1,8'h51,16'h4444, 0,0,0,0,0,0);
    // reads r0@1, r1@2, r0@3; first ack stalled two cycles by r0
    add(1, 1,0,8'h01,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h01,16'h0000, 0,0,0,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 1,0,8'h02,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h02,16'h0000, 0,0,0,0,0,0);
    add(1, 1,0,8'h03,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h03,16'h0000, 0,0,0,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'hAAAA,1,0, 0,0,8'h00,16'h0000, 0,0,1,0,1,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'hAAAA,1,0, 0,0,8'h00,16'h0000, 0,0,1,0,1,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'hAAAA,0,1, 0,0,8'h00,16'h0000, 0,0,1,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'hBBBB,0,0, 0,0,8'h00,16'h0000, 0,0,0,1,0,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'hCCCC,0,0, 0,0,8'h00,16'h0000, 0,0,1,0,0,0);
    // fill the tag queue; 5th read held, and not freed by a same-cycle pop
    add(1, 1,0,8'h60,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h60,16'h0000, 0,0,0,0,0,0);
    add(1, 1,0,8'h61,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h61,16'h0000, 0,0,0,0,0,0);
    add(1, 1,0,8'h62,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h62,16'h0000, 0,0,0,0,0,0);
    add(1, 1,0,8'h63,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h63,16'h0000, 0,0,0,0,0,0);
    add(1, 1,0,8'h64,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 0,0,8'h00,16'h0000, 1,0,0,0,0,0);
    add(1, 1,0,8'h64,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'hDDDD,0,0, 0,0,8'h00,16'h0000, 1,0,1,0,0,0);
    add(1, 1,0,8'h64,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h64,16'h0000, 0,0,0,0,0,0);
    // a write is never blocked by a full queue
    add(1, 0,0,8'h00,16'h0000, 1,1,8'h70,16'h5555, 0, 0,16'h0000,0,0, 1,1,8'h70,16'h5555, 0,0,0,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'h0061,0,0, 0,0,8'h00,16'h0000, 0,0,1,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'h0062,0,0, 0,0,8'h00,16'h0000, 0,0,1,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'h0063,0,0, 0,0,8'h00,16'h0000, 0,0,1,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'h0064,0,0, 0,0,8'h00,16'h0000, 0,0,1,0,0,0);
    // stray ack with an empty queue -> sticky err_ack, cleared by reset
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'hEEEE,0,0, 0,0,8'h00,16'h0000, 0,0,0,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 0,0,8'h00,16'h0000, 0,0,0,0,0,1);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 0,0,8'h00,16'h0000, 0,0,0,0,0,1);
    add(0, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 0,0,8'h00,16'h0000, 1,1,0,0,1,1);
    add(1, 1,0,8'h80,16'h0000, 1,0,8'h81,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h80,16'h0000, 0,1,0,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 1,0,8'h81,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h81,16'h0000, 0,0,0,0,0,0);
    add(1, 1,0,8'h82,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 1,0,8'h82,16'h0000, 0,0,0,0,0,0);
    // reset with three reads outstanding; a later ack finds no owner
    add(0, 1,0,8'h83,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'h1234,0,0, 0,0,8'h00,16'h0000, 1,1,0,0,1,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 1,16'h1234,0,0, 0,0,8'h00,16'h0000, 0,0,0,0,0,0);
    add(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0, 0,16'h0000,0,0, 0,0,8'h00,16'h0000, 0,0,0,0,0,1);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive_vec(vecs[i]);
      @(negedge clk);
      check_vec(i, vecs[i]);
    end

    // contention after reset: both always valid, grants alternate r0,r1,...
    begin
      int n0;
      int n1;
      int got;
      int want;
      n0 = 0;
      n1 = 0;
      @(posedge clk);
      #1;
      drive_idle();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
        r0_req_valid = 1'b1; r0_req_we = 1'b1; r0_req_addr = 8'h90 + 8'(n0);
        r0_req_data  = 16'($urandom_range(0, 65535));
        r1_req_valid = 1'b1; r1_req_we = 1'b1; r1_req_addr = 8'hA0 + 8'(n1);
        r1_req_data  = 16'($urandom_range(0, 65535));
        @(negedge clk);
        want = k % 2;
        got  = (mem_req_valid && !r0_req_retry) ? 0 :
               (mem_req_valid && !r1_req_retry) ? 1 : 2;
        check_val($sformatf("contend_grant%0d", k), got, want);
        check_val($sformatf("contend_addr%0d", k), int'(mem_req_addr),
                  (want == 0) ? 32'h90 + n0 : 32'hA0 + n1);
        if (got == 0) n0++;
        if (got == 1) n1++;
        @(posedge clk);
        #1;
      end
      drive_idle();
      check_val("contend_r0_count", n0, 4);
      check_val("contend_r1_count", n1, 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
